dct_2d_8x8_stream: RTL and testbench



---
 rtl/dct_2d_8x8_stream_pkg.sv | 41 ++++
 rtl/dct_2d_8x8_stream_if.sv | 36 +++
 rtl/dct_1d_8pt.sv | 43 ++++
 rtl/dct_2d_8x8_stream.sv | 130 +++++++++++++
 tb/tb_dct_2d_8x8_stream.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dct_2d_8x8_stream_pkg.sv
// Shared types, constants and helpers for the 8x8 streaming DCT-II engine.
// The cosine table is scaled by 2^COEF_FRAC and already includes c(k)/2.
package dct_pkg;

  localparam int COEF_FRAC = 8;
  localparam int COEF_W    = 9;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic signed [COEF_W-1:0] coef_t;

  // Row k is the basis vector for coefficient k, column n the sample index.
  localparam coef_t COEF_TAB [8][8] = '{
    '{ 9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91,   9'sd91 },
    '{ 9'sd126,  9'sd106,  9'sd71,   9'sd25,  -9'sd25,  -9'sd71,  -9'sd106, -9'sd126 },
    '{ 9'sd118,  9'sd49,  -9'sd49,  -9'sd118, -9'sd118, -9'sd49,   9'sd49,   9'sd118 },
    '{ 9'sd106, -9'sd25,  -9'sd126, -9'sd71,   9'sd71,   9'sd126,  9'sd25,  -9'sd106 },
    '{ 9'sd91,  -9'sd91,  -9'sd91,   9'sd91,   9'sd91,  -9'sd91,  -9'sd91,   9'sd91 },
    '{ 9'sd71,  -9'sd126,  9'sd25,   9'sd106, -9'sd106, -9'sd25,   9'sd126, -9'sd71 },
    '{ 9'sd49,  -9'sd118,  9'sd118, -9'sd49,  -9'sd49,   9'sd118, -9'sd118,  9'sd49 },
    '{ 9'sd25,  -9'sd71,   9'sd106, -9'sd126,  9'sd126, -9'sd106,  9'sd71,  -9'sd25 }
  };

  // Clamp v into the signed range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/dct_2d_8x8_stream_if.sv
// Row-in / column-out stream bundle of the 8x8 DCT engine.
// slave is the engine's view; master is the view of the fetcher/quantiser side.
interface dct_2d_8x8_stream_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
);

  logic               in_valid;
  logic               in_ready;
  logic [8*IN_W-1:0]  data_in;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [8*OUT_W-1:0] data_out;

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_last,
    output data_out
  );

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_last,
    input  data_out
  );

endinterface

// File: rtl/dct_1d_8pt.sv
// Combinational 8-point DCT-II: butterfly pre-adds, constant multiplies,
// round-half-up by 2^COEF_FRAC and saturation to OUT_W. Lane 0 is the MSB lane.
module dct_1d_8pt
  import dct_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 12,
  parameter int COEF_FRAC = dct_pkg::COEF_FRAC
) (
  input  logic [8*IN_W-1:0]  x_i,
  output logic [8*OUT_W-1:0] y_o
);

  logic signed [31:0] xs  [8];
  logic signed [31:0] s   [4];
  logic signed [31:0] d   [4];
  logic signed [31:0] acc [8];

  function automatic logic signed [31:0] round_frac(input logic signed [31:0] v);
    return (v + (32'sd1 <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
  endfunction

  // Even basis rows are symmetric and odd rows antisymmetric about n=3.5,
  // so only the first four table entries of each row are needed.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      xs[n] = 32'(signed'(x_i[(7-n)*IN_W +: IN_W]));
    end
    for (int i = 0; i < 4; i++) begin
      s[i] = xs[i] + xs[7-i];
      d[i] = xs[i] - xs[7-i];
    end
    y_o = '0;
    for (int k = 0; k < 8; k++) begin
      acc[k] = '0;
      for (int i = 0; i < 4; i++) begin
        acc[k] = acc[k] + ((k % 2 == 0) ? s[i] : d[i]) * 32'(COEF_TAB[k][i]);
      end
      y_o[(7-k)*OUT_W +: OUT_W] = OUT_W'(sat(round_frac(acc[k]), OUT_W));
    end
  end

endmodule

// File: rtl/dct_2d_8x8_stream.sv
// 8x8 DCT-II: row DCTs fill a transpose buffer during LOAD, then EMIT streams
// one column DCT per handshake; column 0 forwards the row-7 result directly.
module dct_2d_8x8_stream
  import dct_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int ROW_W     = 12,
  parameter int OUT_W     = 12,
  parameter int COEF_FRAC = dct_pkg::COEF_FRAC
) (
  input logic                clk,
  input logic                rst,
  dct_2d_8x8_stream_if.slave bus
);

  state_e             state_q, state_d;
  logic [2:0]         row_cnt_q, row_cnt_d;
  logic [2:0]         col_cnt_q, col_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [8*OUT_W-1:0] data_out_q, data_out_d;

  logic [8*ROW_W-1:0] tbuf_q [8];
  logic [8*ROW_W-1:0] row_res;
  logic [8*ROW_W-1:0] col_vec;
  logic [8*OUT_W-1:0] col_res;
  logic [2:0]         col_sel;
  int                 csel;
  logic               in_fire;
  logic               out_fire;
  logic               last_row;

  dct_1d_8pt #(
    .IN_W      (IN_W),
    .OUT_W     (ROW_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_row (
    .x_i (bus.data_in),
    .y_o (row_res)
  );

  dct_1d_8pt #(
    .IN_W      (ROW_W),
    .OUT_W     (OUT_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_col (
    .x_i (col_vec),
    .y_o (col_res)
  );

  assign in_fire  = bus.in_valid && (state_q == LOAD);
  assign out_fire = out_valid_q && bus.out_ready;
  assign last_row = in_fire && (row_cnt_q == 3'd7);

  // Gather the column for the next output load; row 7 comes straight from the
  // row pass when it is being accepted this cycle.
  always_comb begin
    col_sel = (state_q == LOAD) ? 3'd0 : col_cnt_q + 3'd1;
    csel    = int'(col_sel);
    col_vec = '0;
    for (int r = 0; r < 8; r++) begin
      if (last_row && r == 7) begin
        col_vec[(7-r)*ROW_W +: ROW_W] = row_res[(7-csel)*ROW_W +: ROW_W];
      end else begin
        col_vec[(7-r)*ROW_W +: ROW_W] = tbuf_q[r][(7-csel)*ROW_W +: ROW_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          row_cnt_d = row_cnt_q + 3'd1;
          if (row_cnt_q == 3'd7) begin
            state_d     = EMIT;
            col_cnt_d   = 3'd0;
            out_valid_d = 1'b1;
            data_out_d  = col_res;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (col_cnt_q == 3'd7) begin
            state_d     = LOAD;
            col_cnt_d   = 3'd0;
            out_valid_d = 1'b0;
          end else begin
            col_cnt_d  = col_cnt_q + 3'd1;
            data_out_d = col_res;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  // Transpose buffer: plain storage, every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      tbuf_q[row_cnt_q] <= row_res;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = (state_q == EMIT) && (col_cnt_q == 3'd7);
  assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_dct_2d_8x8_stream.sv
// Directed bench for the 8x8 DCT engine: a 12-bit output instance and a 10-bit
// output instance run in lockstep on the same row stream.
module tb_dct_2d_8x8_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dct_2d_8x8_stream_if #(.IN_W(8), .OUT_W(12)) bus ();
  dct_2d_8x8_stream_if #(.IN_W(8), .OUT_W(10)) bus_n ();

  assign bus_n.in_valid  = bus.in_valid;
  assign bus_n.data_in   = bus.data_in;
  assign bus_n.out_ready = bus.out_ready;

  dct_2d_8x8_stream #(.IN_W(8), .ROW_W(12), .OUT_W(12), .COEF_FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dct_2d_8x8_stream #(.IN_W(8), .ROW_W(12), .OUT_W(10), .COEF_FRAC(8)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  int checks = 0;
  int errors = 0;

  // Impulse of 64 at x[0][0]: row 0 gives r = {23,32,30,27,23,18,12,6},
  // column c coefficient k = (r[c]*C(k,0) + 128) >>> 8. Indexed [column][k].
  int imp_exp [8][8] = '{
    '{ 8, 11, 11, 10,  8,  6,  4,  2},
    '{11, 16, 15, 13, 11,  9,  6,  3},
    '{11, 15, 14, 12, 11,  8,  6,  3},
    '{10, 13, 12, 11, 10,  7,  5,  3},
    '{ 8, 11, 11, 10,  8,  6,  4,  2},
    '{ 6,  9,  8,  7,  6,  5,  3,  2},
    '{ 4,  6,  6,  5,  4,  3,  2,  1},
    '{ 2,  3,  3,  2,  2,  2,  1,  1}
  };

  logic [95:0] d12;
  logic [79:0] d10;
  logic        lst;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int l12(input logic [95:0] v, input int k);
    logic signed [11:0] t;
    t = v[(7-k)*12 +: 12];
    return int'(t);
  endfunction

  function automatic int l10(input logic [79:0] v, input int k);
    logic signed [9:0] t;
    t = v[(7-k)*10 +: 10];
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [63:0] row);
    int n;
    bus.in_valid = 1'b1;
    bus.data_in  = row;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("in_ready wait", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_col(input int budget, output logic [95:0] o12,
                          output logic [79:0] o10, output logic olast);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("out_valid wait", int'(bus.out_valid), 1);
    o12   = bus.data_out;
    o10   = bus_n.data_out;
    olast = bus.out_last;
    tick();
  endtask

  function automatic logic [63:0] imp_row(input int r);
    return (r == 0) ? {8'sd64, 56'd0} : 64'd0;
  endfunction

  task automatic check_imp_cols(input string tag, input int first, input int budget0);
    for (int c = first; c < 8; c++) begin
      recv_col((c == first) ? budget0 : 0, d12, d10, lst);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("%s c%0d k%0d", tag, c, k), l12(d12, k), imp_exp[c][k]);
      end
      chk($sformatf("%s last c%0d", tag, c), int'(lst), (c == 7) ? 1 : 0);
    end
  endtask

  initial begin
    real pi, cu, cv, gold, diff;
    pi = 3.14159265358979;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;
    tick();
    chk("reset in_ready", int'(bus.in_ready), 1);
    chk("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_last", int'(bus.out_last), 0);
    chk("reset data_out zero", int'(bus.data_out == '0), 1);
    tick();
    rst = 1'b0;
    tick();

    // Constant 100 block, both sides always ready.
    for (int r = 0; r < 8; r++) begin
      send_row({8{8'd100}});
      if (r == 6) chk("const early out_valid", int'(bus.out_valid), 0);
    end
    chk("const latency out_valid", int'(bus.out_valid), 1);
    chk("const emit in_ready", int'(bus.in_ready), 0);
    for (int c = 0; c < 8; c++) begin
      recv_col(0, d12, d10, lst);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("const c%0d k%0d", c, k), l12(d12, k), (c == 0 && k == 0) ? 808 : 0);
      end
      chk($sformatf("const last c%0d", c), int'(lst), (c == 7) ? 1 : 0);
      if (c == 0) chk("const w10 positive sat", l10(d10, 0), 511);
    end
    chk("const done out_valid", int'(bus.out_valid), 0);
    chk("const done in_ready", int'(bus.in_ready), 1);

    // Full negative scale, 12-bit and 10-bit outputs.
    for (int r = 0; r < 8; r++) send_row({8{8'h80}});
    for (int c = 0; c < 8; c++) begin
      recv_col(0, d12, d10, lst);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("neg w12 c%0d k%0d", c, k), l12(d12, k), (c == 0 && k == 0) ? -1035 : 0);
        chk($sformatf("neg w10 c%0d k%0d", c, k), l10(d10, k), (c == 0 && k == 0) ? -512 : 0);
      end
    end

    // Impulse, with a floating-point reference allowed 1 LSB of slack.
    for (int r = 0; r < 8; r++) send_row(imp_row(r));
    for (int c = 0; c < 8; c++) begin
      recv_col(0, d12, d10, lst);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("imp c%0d k%0d", c, k), l12(d12, k), imp_exp[c][k]);
        cu = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        cv = (c == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        gold = 64.0 * cu * cv / 4.0 * $cos(k * pi / 16.0) * $cos(c * pi / 16.0);
        diff = l12(d12, k) - gold;
        chk($sformatf("imp float c%0d k%0d", c, k), int'(diff <= 1.0 && diff >= -1.0), 1);
      end
    end

    // Backpressure on column 3, with a stray in_valid that must be ignored.
    for (int r = 0; r < 8; r++) send_row(imp_row(r));
    for (int c = 0; c < 3; c++) begin
      recv_col(0, d12, d10, lst);
      chk($sformatf("bp c%0d k0", c), l12(d12, 0), imp_exp[c][0]);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = {8{8'd7}};
    for (int s = 0; s < 5; s++) begin
      tick();
      chk($sformatf("bp stall%0d out_valid", s), int'(bus.out_valid), 1);
      chk($sformatf("bp stall%0d in_ready", s), int'(bus.in_ready), 0);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("bp stall%0d k%0d", s, k), l12(bus.data_out, k), imp_exp[3][k]);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_imp_cols("bp", 3, 0);
    chk("bp done in_ready", int'(bus.in_ready), 1);

    // Bubbled input: in_valid toggles every cycle.
    for (int r = 0; r < 8; r++) begin
      send_row(imp_row(r));
      if (r < 7) tick();
      if (r == 6) chk("bubble early out_valid", int'(bus.out_valid), 0);
    end
    check_imp_cols("bubble", 0, 0);

    // Reset after four rows, then a fresh impulse block.
    for (int r = 0; r < 4; r++) send_row({8{8'd100}});
    #1 rst = 1'b1;
    #1;
    chk("midrst in_ready", int'(bus.in_ready), 1);
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst out_last", int'(bus.out_last), 0);
    chk("midrst data_out zero", int'(bus.data_out == '0), 1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 8; r++) send_row(imp_row(r));
    check_imp_cols("fresh", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
